// File: rtl/branch_resolve_bht.sv
// MIPS conditional-branch resolver with a PC-indexed table of 2-bit saturating
// predictors. It produces a registered EX-stage outcome, a mispredict flag and a redirect PC.
module branch_resolve_bht #(
    parameter int          DATA_W    = 32,
    parameter int          PC_W      = 32,
    parameter int          BHT_IDX_W = 6,
    parameter logic [1:0]  CTR_INIT  = 2'b01,
    parameter int          CNT_W     = 32
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              stall,
    input  logic              flush,
    input  logic              id_valid,
    input  logic [5:0]        id_label,
    input  logic [PC_W-1:0]   id_pc,
    input  logic [PC_W-1:0]   id_target,
    input  logic [DATA_W-1:0] id_srca,
    input  logic [DATA_W-1:0] id_srcb,
    output logic              pred_taken,
    output logic              ex_valid,
    output logic              ex_taken,
    output logic              ex_link,
    output logic              mispredict,
    output logic [PC_W-1:0]   redirect_pc,
    output logic [CNT_W-1:0]  branch_cnt,
    output logic [CNT_W-1:0]  miss_cnt
);
    localparam int DEPTH = 1 << BHT_IDX_W;

    localparam logic [5:0] L_BEQ    = 6'b011101;
    localparam logic [5:0] L_BNE    = 6'b011110;
    localparam logic [5:0] L_BGEZ   = 6'b011111;
    localparam logic [5:0] L_BGTZ   = 6'b100000;
    localparam logic [5:0] L_BLEZ   = 6'b100001;
    localparam logic [5:0] L_BLTZ   = 6'b100010;
    localparam logic [5:0] L_BGEZAL = 6'b100011;
    localparam logic [5:0] L_BLTZAL = 6'b100100;

    logic                     is_br;
    logic                     is_link;
    logic                     cond;
    logic                     capture;
    logic [BHT_IDX_W-1:0]     idx;
    logic [2*DEPTH-1:0]       table_flat;
    logic signed [DATA_W-1:0] sa;
    logic signed [DATA_W-1:0] sb;

    logic             ex_valid_q, ex_valid_d;
    logic             ex_taken_q, ex_taken_d;
    logic             ex_link_q, ex_link_d;
    logic             mispredict_q, mispredict_d;
    logic [PC_W-1:0]  redirect_pc_q, redirect_pc_d;
    logic [CNT_W-1:0] branch_cnt_q, branch_cnt_d;
    logic [CNT_W-1:0] miss_cnt_q, miss_cnt_d;

    assign sa  = id_srca;
    assign sb  = id_srcb;
    assign idx = id_pc[BHT_IDX_W+1:2];

    always_comb begin
        is_br   = 1'b0;
        is_link = 1'b0;
        cond    = 1'b0;
        case (id_label)
            L_BEQ:    begin is_br = 1'b1; cond = (sa == sb); end
            L_BNE:    begin is_br = 1'b1; cond = (sa != sb); end
            L_BGEZ:   begin is_br = 1'b1; cond = (sa >= 0); end
            L_BGTZ:   begin is_br = 1'b1; cond = (sa > 0); end
            L_BLEZ:   begin is_br = 1'b1; cond = (sa <= 0); end
            L_BLTZ:   begin is_br = 1'b1; cond = (sa < 0); end
            L_BGEZAL: begin is_br = 1'b1; is_link = 1'b1; cond = (sa >= 0); end
            L_BLTZAL: begin is_br = 1'b1; is_link = 1'b1; cond = (sa < 0); end
            default:  ;
        endcase
        is_br = is_br & id_valid;
    end

    // Prediction uses the pre-update counter MSB; a same-cycle update is not bypassed.
    assign pred_taken = is_br & table_flat[{idx, 1'b1}];
    assign capture    = is_br & ~stall & ~flush;

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_bht
            logic [1:0] ctr_q, ctr_d;

            always_comb begin
                ctr_d = ctr_q;
                if (capture && idx == BHT_IDX_W'(gi)) begin
                    if (cond && ctr_q != 2'b11)
                        ctr_d = ctr_q + 2'b01;
                    else if (!cond && ctr_q != 2'b00)
                        ctr_d = ctr_q - 2'b01;
                end
            end

            always_ff @(posedge clk) begin
                if (!resetn)
                    ctr_q <= CTR_INIT;
                else
                    ctr_q <= ctr_d;
            end

            assign table_flat[2*gi +: 2] = ctr_q;
        end
    endgenerate

    always_comb begin
        ex_valid_d    = ex_valid_q;
        ex_taken_d    = ex_taken_q;
        ex_link_d     = ex_link_q;
        mispredict_d  = mispredict_q;
        redirect_pc_d = redirect_pc_q;
        branch_cnt_d  = branch_cnt_q;
        miss_cnt_d    = miss_cnt_q;
        if (capture) begin
            ex_valid_d    = 1'b1;
            ex_taken_d    = cond;
            ex_link_d     = is_link;
            mispredict_d  = cond ^ pred_taken;
            redirect_pc_d = cond ? id_target : id_pc + PC_W'(8);
            branch_cnt_d  = branch_cnt_q + CNT_W'(1);
            if (cond ^ pred_taken)
                miss_cnt_d = miss_cnt_q + CNT_W'(1);
        end else if (flush || !stall) begin
            // A bubble enters EX; redirect_pc keeps its last value.
            ex_valid_d   = 1'b0;
            ex_taken_d   = 1'b0;
            ex_link_d    = 1'b0;
            mispredict_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            ex_valid_q    <= 1'b0;
            ex_taken_q    <= 1'b0;
            ex_link_q     <= 1'b0;
            mispredict_q  <= 1'b0;
            redirect_pc_q <= '0;
            branch_cnt_q  <= '0;
            miss_cnt_q    <= '0;
        end else begin
            ex_valid_q    <= ex_valid_d;
            ex_taken_q    <= ex_taken_d;
            ex_link_q     <= ex_link_d;
            mispredict_q  <= mispredict_d;
            redirect_pc_q <= redirect_pc_d;
            branch_cnt_q  <= branch_cnt_d;
            miss_cnt_q    <= miss_cnt_d;
        end
    end

    assign ex_valid    = ex_valid_q;
    assign ex_taken    = ex_taken_q;
    assign ex_link     = ex_link_q;
    assign mispredict  = mispredict_q;
    assign redirect_pc = redirect_pc_q;
    assign branch_cnt  = branch_cnt_q;
    assign miss_cnt    = miss_cnt_q;

endmodule

// File: tb/tb_branch_resolve_bht.sv
// Directed plus randomized bench for branch_resolve_bht. The reference model
// works on integer branch semantics and an array of saturating counters.
module tb_branch_resolve_bht;
    localparam logic [5:0] BEQ = 6'b011101, BNE = 6'b011110, BGEZ = 6'b011111, BGTZ = 6'b100000;
    localparam logic [5:0] BLEZ = 6'b100001, BLTZ = 6'b100010, BGEZAL = 6'b100011, BLTZAL = 6'b100100;

    logic        clk = 1'b0;
    logic        resetn, stall, flush, id_valid;
    logic [5:0]  id_label;
    logic [31:0] id_pc, id_target, id_srca, id_srcb;
    logic        pred_taken, ex_valid, ex_taken, ex_link, mispredict;
    logic [31:0] redirect_pc, branch_cnt, miss_cnt;

    branch_resolve_bht dut (
        .clk(clk), .resetn(resetn), .stall(stall), .flush(flush),
        .id_valid(id_valid), .id_label(id_label), .id_pc(id_pc),
        .id_target(id_target), .id_srca(id_srca), .id_srcb(id_srcb),
        .pred_taken(pred_taken), .ex_valid(ex_valid), .ex_taken(ex_taken),
        .ex_link(ex_link), .mispredict(mispredict), .redirect_pc(redirect_pc),
        .branch_cnt(branch_cnt), .miss_cnt(miss_cnt)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference state
    int          m_bht [64];
    bit          m_valid, m_taken, m_link, m_miss;
    bit [31:0]   m_redir, m_bcnt, m_mcnt;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit model_is_branch(input logic [5:0] lab);
        return lab inside {BEQ, BNE, BGEZ, BGTZ, BLEZ, BLTZ, BGEZAL, BLTZAL};
    endfunction

    function automatic bit model_cond(input logic [5:0] lab, input logic [31:0] a, input logic [31:0] b);
        int sa, sb;
        sa = int'(a);
        sb = int'(b);
        case (lab)
            BEQ:            return sa == sb;
            BNE:            return sa != sb;
            BGEZ, BGEZAL:   return sa >= 0;
            BGTZ:           return sa > 0;
            BLEZ:           return sa <= 0;
            default:        return sa < 0;
        endcase
    endfunction

    // One clock: drive, check prediction, advance the model, check EX outputs.
    task automatic step(input bit rn, input bit st, input bit fl, input bit v, input logic [5:0] lab,
                        input logic [31:0] pc, input logic [31:0] tgt,
                        input logic [31:0] a, input logic [31:0] b);
        bit br, c, p;
        int ix;
        @(negedge clk);
        resetn = rn; stall = st; flush = fl; id_valid = v; id_label = lab;
        id_pc = pc; id_target = tgt; id_srca = a; id_srcb = b;
        #1;
        br = v && model_is_branch(lab);
        ix = int'(pc[7:2]);
        p  = br && (m_bht[ix] >= 2);
        c  = model_cond(lab, a, b);
        if (rn) chk("pred_taken", 32'(pred_taken), 32'(p));
        if (!rn) begin
            foreach (m_bht[i]) m_bht[i] = 1;
            m_valid = 0; m_taken = 0; m_link = 0; m_miss = 0;
            m_redir = 0; m_bcnt = 0; m_mcnt = 0;
        end else if (br && !st && !fl) begin
            m_valid = 1;
            m_taken = c;
            m_link  = (lab == BGEZAL) || (lab == BLTZAL);
            m_miss  = (c != p);
            m_redir = c ? tgt : pc + 32'd8;
            m_bcnt  = m_bcnt + 1;
            if (c != p) m_mcnt = m_mcnt + 1;
            m_bht[ix] = c ? ((m_bht[ix] == 3) ? 3 : m_bht[ix] + 1)
                          : ((m_bht[ix] == 0) ? 0 : m_bht[ix] - 1);
        end else if (fl || !st) begin
            m_valid = 0; m_taken = 0; m_link = 0; m_miss = 0;
        end
        @(posedge clk);
        #1;
        chk("ex_valid",    32'(ex_valid),   32'(m_valid));
        chk("ex_taken",    32'(ex_taken),   32'(m_taken));
        chk("ex_link",     32'(ex_link),    32'(m_link));
        chk("mispredict",  32'(mispredict), 32'(m_miss));
        chk("redirect_pc", redirect_pc,     m_redir);
        chk("branch_cnt",  branch_cnt,      m_bcnt);
        chk("miss_cnt",    miss_cnt,        m_mcnt);
    endtask

    // Prediction-only probe (no capture: id_valid with stall held)
    task automatic probe_pred(input logic [31:0] pc, input bit exp);
        @(negedge clk);
        resetn = 1; stall = 1; flush = 0; id_valid = 1; id_label = BEQ; id_pc = pc;
        #1;
        chk("probe_pred", 32'(pred_taken), 32'(exp));
    endtask

    logic [5:0] labs [8];
    logic [31:0] rpc, ra, rb;
    logic [5:0]  rlab;

    initial begin
        labs = '{BEQ, BNE, BGEZ, BGTZ, BLEZ, BLTZ, BGEZAL, BLTZAL};
        foreach (m_bht[i]) m_bht[i] = 1;
        resetn = 0; stall = 0; flush = 0; id_valid = 0; id_label = 0;
        id_pc = 0; id_target = 0; id_srca = 0; id_srcb = 0;

        step(0, 0, 0, 1, BEQ, 32'h0040_0010, 32'h0040_0100, 5, 5);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0);

        // Train index 4: first BEQ mispredicts, then two correct taken predictions.
        step(1, 0, 0, 1, BEQ, 32'h0040_0010, 32'h0040_0100, 5, 5);
        step(1, 0, 0, 1, BEQ, 32'h0040_0010, 32'h0040_0100, 5, 5);
        step(1, 0, 0, 1, BEQ, 32'h0040_0010, 32'h0040_0100, 5, 5);
        step(1, 0, 0, 1, BLTZAL, 32'h0040_0020, 32'h0040_0200, 32'hFFFF_FFFF, 0);
        step(1, 0, 0, 1, BGTZ, 32'h0040_0030, 32'h0040_0300, 0, 0);
        // BNE held under stall, then released.
        for (int i = 0; i < 3; i++)
            step(1, 1, 0, 1, BNE, 32'h0040_0040, 32'h0040_0400, 1, 2);
        step(1, 0, 0, 1, BNE, 32'h0040_0040, 32'h0040_0400, 1, 2);
        // Flush wins over stall.
        step(1, 1, 1, 1, BEQ, 32'h0040_0010, 32'h0040_0100, 7, 7);
        step(1, 0, 0, 1, 6'b000000, 32'h0040_0010, 32'h0040_0100, 7, 7);
        // Reset after training brings the prediction back to not-taken.
        step(0, 1, 0, 1, BEQ, 32'h0040_0010, 32'h0040_0100, 5, 5);
        probe_pred(32'h0040_0010, 1'b0);

        for (int n = 0; n < 3000; n++) begin
            rpc  = (($urandom_range(0, 3) == 0) ? $urandom : 32'h0040_0000 + 4 * $urandom_range(0, 7));
            rlab = ($urandom_range(0, 9) == 0) ? 6'($urandom) : labs[$urandom_range(0, 7)];
            ra   = ($urandom_range(0, 2) == 0) ? $urandom : 32'($signed($urandom_range(0, 4)) - 2);
            rb   = ($urandom_range(0, 2) == 0) ? $urandom : 32'($signed($urandom_range(0, 4)) - 2);
            step($urandom_range(0, 199) != 0, $urandom_range(0, 4) == 0, $urandom_range(0, 7) == 0,
                 $urandom_range(0, 9) != 0, rlab, rpc, $urandom, ra, rb);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/branch_resolve_bht.md
Name: branch_resolve_bht

Overview:
- Parametrised successor to the decode-stage branch condition decoder.
- Evaluates MIPS conditional branches (BEQ/BNE/BGEZ/BGTZ/BLEZ/BLTZ/BGEZAL/BLTZAL) and registers the outcome into EX.
- Keeps a table of 2-bit saturating predictors indexed by PC and supplies a combinational prediction to fetch/decode.
- Produces a registered mispredict flag and redirect PC for the pipeline, plus performance counters.

Parameters:
DATA_W, 32, width of the compared operands
PC_W, 32, width of PC and target
BHT_IDX_W, 6, log2 of predictor table depth (64 entries)
CTR_INIT, 2'b01, reset value of every predictor counter (weakly not-taken)
CNT_W, 32, width of the performance counters

Ports:
clk  in  1  clock
resetn  in  1  synchronous active-low reset
stall  in  1  pipeline stall; holds EX outputs and blocks table/counter updates
flush  in  1  kills the instruction being captured this cycle
id_valid  in  1  decode stage holds a valid instruction
id_label  in  6  instruction label: 011101 BEQ, 011110 BNE, 011111 BGEZ, 100000 BGTZ, 100001 BLEZ, 100010 BLTZ, 100011 BGEZAL, 100100 BLTZAL
id_pc  in  PC_W  PC of the decode instruction
id_target  in  PC_W  branch target address
id_srca  in  DATA_W  operand rs
id_srcb  in  DATA_W  operand rt
pred_taken  out  1  combinational prediction for id_pc
ex_valid  out  1  registered: a branch resolved last capture
ex_taken  out  1  registered actual outcome
ex_link  out  1  registered: branch is BGEZAL/BLTZAL (link write required regardless of outcome)
mispredict  out  1  registered: actual != predicted
redirect_pc  out  PC_W  registered correct next PC
branch_cnt  out  CNT_W  resolved branches
miss_cnt  out  CNT_W  mispredicted branches

Behaviour:
- is_br = id_valid & id_label in the eight codes above. Any other label is not a branch: no capture, no update.
- Index idx = id_pc[BHT_IDX_W+1:2].
- pred_taken = is_br & bht[idx][1]. Purely combinational from the current table state.
- Condition evaluation: signed compares on DATA_W.
  - BEQ: a==b. BNE: a!=b.
  - BGEZ/BGEZAL: a>=0. BGTZ: a>0. BLEZ: a<=0. BLTZ/BLTZAL: a<0.
- Capture = is_br & !stall & !flush. On a capture edge:
  - ex_valid<=1, ex_taken<=cond, ex_link<=(label is BGEZAL/BLTZAL).
  - mispredict<=(cond != pred_taken).
  - redirect_pc<=cond ? id_target : id_pc+8 (PC_W modulo wrap).
  - bht[idx] counter: +1 if cond, -1 if not; saturates at 2'b11 and 2'b00.
  - branch_cnt+1; miss_cnt+1 if mispredicted. Counters wrap modulo 2^CNT_W.
- No capture:
  - stall=1 and flush=0: all registered outputs, table and counters hold.
  - Otherwise (flush=1, or no branch): ex_valid, ex_taken, ex_link and mispredict clear to 0; redirect_pc holds; no table or counter update.
  - flush has priority over stall.
- Latency: one clock from decode inputs to EX outputs. Table update becomes visible to pred_taken the cycle after the capture edge.
- Same-cycle read/update of the same index: pred_taken reflects the pre-update value; there is no bypass.
- Reset (resetn=0 at a clk edge, any time including mid-stall):
  - All bht entries <= CTR_INIT.
  - ex_valid, ex_taken, ex_link, mispredict, redirect_pc, branch_cnt, miss_cnt <= 0.
  - Inputs are ignored in the reset cycle.
- mispredict is only meaningful while ex_valid=1; it is never 1 when ex_valid=0.

Test Plan:
- After reset, BEQ pc=0x00400010, a=b=5, target=0x00400100 -> pred_taken=0. Next cycle: ex_valid=1, ex_taken=1, mispredict=1, redirect_pc=0x00400100, branch_cnt=1, miss_cnt=1. bht[4]=2'b10.
- Repeat the same BEQ twice more -> pred_taken=1 on both. Both give mispredict=0. bht[4] saturates at 2'b11. miss_cnt stays 1.
- BLTZAL a=0xFFFFFFFF at pc=0x00400020 -> ex_taken=1, ex_link=1. BGTZ a=0 -> ex_taken=0, redirect_pc=pc+8.
- BNE held with stall=1 for 3 cycles -> outputs and counters unchanged during the stall. Capture occurs on the first cycle with stall=0.
- BEQ with flush=1 and stall=1 -> ex_valid=0 next cycle, bht unchanged, branch_cnt unchanged.
- resetn=0 for one edge after training bht[4]=2'b11 -> pred_taken for pc=0x00400010 returns to 0, and all counters read 0.
